ioctl_sdram_loader: RTL and testbench

IOCTL_SDRAM_LOADER -- requirements
Module: ioctl_sdram_loader

---
 rtl/pcfx_load_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/ioctl_sdram_loader.sv | 123 ++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcfx_load_pkg.sv
// Shared definitions for the HPS-to-SDRAM ROM loader: FSM states, file indices
// and the BIOS region size.
package pcfx_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } load_state_e;

  localparam logic [5:0]  IDX_BIOS  = 6'd0;
  localparam logic [24:0] BIOS_SIZE = 25'h100000;

  // HPS files arrive little-endian; the SDRAM image expects the bytes swapped.
  function automatic logic [15:0] bios_swap(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty
// are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Streams HPS ioctl downloads into SDRAM through a small write FIFO, holding
// the core in reset while a load is in progress.
module ioctl_sdram_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] BIOS_SIZE  = pcfx_load_pkg::BIOS_SIZE
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        ram_req,
  output logic [24:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_ack,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  state_dbg
);

  import pcfx_load_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 24 + 16;

  load_state_e   state;
  load_state_e   state_nxt;
  logic          dl_q;
  logic [5:0]    idx_q;
  logic          err_q;
  logic          req_q;

  logic          start;
  logic          wr_bios;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          err_set;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_bits;

  assign unused_bits = ^{ioctl_index[7:6], ioctl_addr[0]};

  assign start    = (state == ST_IDLE) && ioctl_download && !dl_q;
  assign wr_bios  = (state == ST_ACTIVE) && ioctl_wr && (idx_q == IDX_BIOS);
  assign in_range = (ioctl_addr < BIOS_SIZE);
  assign push     = wr_bios && in_range && !fifo_full;
  assign err_set  = wr_bios && (!in_range || fifo_full);

  // SDRAM handshake: ram_req rises with the FIFO head on ram_addr/ram_wdata and
  // holds them unchanged until the controller answers with a one-cycle ram_ack;
  // that cycle pops the head and drops ram_req, so only one request is in flight.
  assign pop = req_q && ram_ack;

  assign fifo_wdata = {ioctl_addr[24:1], bios_swap(ioctl_dout)};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!ioctl_download) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && !req_q && !ram_ack) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // dl_q resets high so a download already active at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      dl_q  <= 1'b1;
      idx_q <= '0;
      err_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      dl_q  <= ioctl_download;
      if (start) begin
        idx_q <= ioctl_index[5:0];
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (pop)                       req_q <= 1'b0;
      else if (!req_q && !fifo_empty) req_q <= 1'b1;
    end
  end

  assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign ram_req    = req_q;
  assign ram_addr   = {fifo_rdata[FW-1:16], 1'b0};
  assign ram_wdata  = fifo_rdata[15:0];
  assign core_hold  = (state == ST_ACTIVE) || (state == ST_DRAIN);
  assign load_done  = (state == ST_DONE);
  assign load_err   = err_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Randomised bench for ioctl_sdram_loader: a reference model predicts every
// SDRAM write and the error flag; a monitor checks what the DUT emits.
module tb_ioctl_sdram_loader;

  import pcfx_load_pkg::*;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [24:0] BIOS_LIMIT = 25'h100000;

  // clock / reset
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index    = 8'd0;
  logic        ioctl_wr       = 1'b0;
  logic [24:0] ioctl_addr     = '0;
  logic [15:0] ioctl_dout     = '0;
  logic        ioctl_wait;
  logic        ram_req;
  logic [24:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack        = 1'b0;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  state_dbg;

  ioctl_sdram_loader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BIOS_SIZE  (BIOS_LIMIT)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ram_req        (ram_req),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_ack        (ram_ack),
    .core_hold      (core_hold),
    .load_done      (load_done),
    .load_err       (load_err),
    .state_dbg      (state_dbg)
  );

  // reference model state
  logic [40:0] exp_q[$];
  logic        in_load  = 1'b0;
  logic [7:0]  cur_idx  = 8'd0;
  logic        exp_err  = 1'b0;

  int n_checks   = 0;
  int n_errors   = 0;
  int ack_dly    = 0;
  int ack_cnt    = 0;
  int req_cycles = 0;
  int done_cnt   = 0;
  logic wait_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SDRAM controller model with programmable acceptance latency
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      ram_ack = 1'b0;
      ack_cnt = 0;
    end else if (ram_ack) begin
      ram_ack = 1'b0;
      ack_cnt = 0;
    end else if (ram_req) begin
      if (ack_cnt >= ack_dly) ram_ack = 1'b1;
      else ack_cnt++;
    end
  end

  // monitor / scoreboard
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic        prev_hold = 1'b0;
  logic [24:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  always @(negedge clk_sys) begin
    #1;
    if (reset_n) begin
      chk("wait_level", ioctl_wait, (exp_q.size() >= FIFO_DEPTH - 1));
      if (ioctl_wait) wait_seen = 1'b1;
      if (ram_req) begin
        req_cycles++;
        if (prev_req && !prev_ack) begin
          chk("addr_stable", ram_addr, prev_addr);
          chk("data_stable", ram_wdata, prev_data);
        end
      end
      if (ram_req && ram_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {ram_addr, ram_wdata}, 41'h0);
        end else begin
          logic [40:0] e;
          e = exp_q.pop_front();
          chk("ram_addr", ram_addr, e[40:16]);
          chk("ram_wdata", ram_wdata, e[15:0]);
        end
      end
      if (load_done) begin
        done_cnt++;
        chk("hold_falls_with_done", {prev_hold, core_hold}, 2'b10);
      end
    end
    prev_req  = ram_req;
    prev_ack  = ram_ack;
    prev_hold = core_hold;
    prev_addr = ram_addr;
    prev_data = ram_wdata;
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic start_load(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys);
    in_load = 1'b1;
    cur_idx = idx;
    exp_err = 1'b0;
  endtask

  task automatic do_write(input logic [24:0] addr, input logic [15:0] data, input logic respect);
    int  guard;
    logic accept;
    guard = 0;
    @(negedge clk_sys);
    while (respect && ioctl_wait && guard < 500) begin
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 500) chk("wait_release", ioctl_wait, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    accept     = 1'b0;
    if (in_load && cur_idx[5:0] == 6'd0) begin
      if (addr < BIOS_LIMIT && exp_q.size() < FIFO_DEPTH) accept = 1'b1;
      else exp_err = 1'b1;
    end
    @(posedge clk_sys);
    if (accept) exp_q.push_back({addr[24:1], 1'b0, data[7:0], data[15:8]});
  endtask

  task automatic finish_load();
    logic found;
    int   d0;
    d0 = done_cnt;
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    in_load = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_sys);
      #2;
      if (load_done) found = 1'b1;
    end
    chk("load_done_seen", found, 1'b1);
    chk("load_err", load_err, exp_err);
    chk("all_written", exp_q.size(), 0);
    chk("done_pulses", done_cnt - d0, 1);
    @(negedge clk_sys);
    #2;
    chk("done_one_cycle", load_done, 1'b0);
    chk("idle_after_done", state_dbg, ST_IDLE);
  endtask

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int          r0;
    logic [24:0] a;
    logic [7:0]  idx_tab [7];
    idx_tab = '{8'h00, 8'h00, 8'h00, 8'h40, 8'hC0, 8'h03, 8'h3F};

    // reset state, checked before any clock edge
    #3;
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_hold", core_hold, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_state", state_dbg, ST_IDLE);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    idle(3);

    // eight words of 16'h1234 at 0..14
    ack_dly = 2;
    start_load(8'd0);
    for (int i = 0; i < 8; i++) do_write(25'(2 * i), 16'h1234, 1'b1);
    finish_load();

    // slow SDRAM, writes every cycle while wait is low
    ack_dly   = 10;
    wait_seen = 1'b0;
    start_load(8'd0);
    for (int i = 0; i < 8; i++) do_write(25'(16 + 2 * i), 16'($urandom), 1'b1);
    chk("wait_asserted", wait_seen, 1'b1);
    finish_load();

    // out-of-range address, then error clears on next start
    ack_dly = 1;
    r0 = req_cycles;
    start_load(8'd0);
    do_write(25'h100000, 16'hBEEF, 1'b1);
    finish_load();
    chk("oor_no_req", req_cycles - r0, 0);
    start_load(8'd0);
    @(negedge clk_sys);
    #2;
    chk("err_cleared_on_start", load_err, 1'b0);
    chk("hold_in_active", core_hold, 1'b1);
    finish_load();

    // unsupported index: silently dropped, no back-pressure
    r0        = req_cycles;
    wait_seen = 1'b0;
    start_load(8'd5);
    for (int i = 0; i < 4; i++) do_write(25'(2 * i), 16'($urandom), 1'b0);
    finish_load();
    chk("unsup_no_req", req_cycles - r0, 0);
    chk("unsup_no_wait", wait_seen, 1'b0);

    // writes outside a load are ignored
    r0 = req_cycles;
    do_write(25'h40, 16'h5555, 1'b0);
    idle(4);
    chk("idle_wr_ignored", req_cycles - r0, 0);

    // overflow when back-pressure is ignored
    ack_dly = 40;
    start_load(8'd0);
    for (int i = 0; i < 5; i++) do_write(25'(32 + 2 * i), 16'($urandom), 1'b0);
    finish_load();

    // reset mid-load with requests pending
    ack_dly = 20;
    start_load(8'd0);
    for (int i = 0; i < 3; i++) do_write(25'(64 + 2 * i), 16'($urandom), 1'b1);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    #2;
    chk("req_before_reset", ram_req, 1'b1);
    @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    in_load = 1'b0;
    #1;
    chk("async_req", ram_req, 1'b0);
    chk("async_wait", ioctl_wait, 1'b0);
    chk("async_hold", core_hold, 1'b0);
    chk("async_done", load_done, 1'b0);
    chk("async_err", load_err, 1'b0);
    chk("async_state", state_dbg, ST_IDLE);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    #2;
    chk("no_restart_state", state_dbg, ST_IDLE);
    chk("no_restart_hold", core_hold, 1'b0);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    idle(2);

    // download falls with two entries outstanding
    ack_dly = 6;
    start_load(8'd0);
    do_write(25'h200, 16'hA1B2, 1'b1);
    do_write(25'h202, 16'hC3D4, 1'b1);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    #2;
    chk("drain_state", state_dbg, ST_DRAIN);
    chk("drain_hold", core_hold, 1'b1);
    ioctl_download = 1'b1;
    start_load(8'd0);
    finish_load();

    // randomised loads
    for (int l = 0; l < 6; l++) begin
      ack_dly = $urandom_range(0, 4);
      start_load(idx_tab[$urandom_range(0, 6)]);
      for (int w = 0; w < $urandom_range(1, 10); w++) begin
        a = 25'($urandom_range(0, 32'hFFFFF));
        if ($urandom_range(0, 7) == 0) a = BIOS_LIMIT + 25'($urandom_range(0, 1023));
        do_write(a, 16'($urandom), 1'b1);
      end
      finish_load();
    end

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
